// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// Uses a double-buffered display word, commits new data only at frame boundaries, and blanks all anodes for a guard interval at the start of each slot.
module seg_scan_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  dp_in,
    output logic [3:0]  hex_out,
    output logic [7:0]  anode,
    output logic        dp,
    output logic        pending,
    output logic        frame_start
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc_reg;
    logic [2:0]    idx_reg;
    logic [31:0]   buf_reg;
    logic [31:0]   shadow_reg;
    logic          pending_reg;
    logic          frame_start_reg;

    logic tick;
    logic boundary;
    logic guard_on;
    logic dark;

    assign tick     = (presc_reg == PW'(TICK_DIV - 1));
    assign boundary = tick && (idx_reg == 3'd7);

    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_on = 1'b0;
        end else begin : g_guard
            assign guard_on = (presc_reg < PW'(GUARD));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg       <= '0;
            idx_reg         <= '0;
            buf_reg         <= '0;
            shadow_reg      <= '0;
            pending_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            presc_reg       <= tick ? '0 : presc_reg + PW'(1);
            frame_start_reg <= boundary;
            if (tick) begin
                idx_reg <= idx_reg + 3'd1;
            end
            // The shadow takes the old buffer even when a load lands on the same edge.
            if (boundary && pending_reg) begin
                shadow_reg <= buf_reg;
            end
            if (load) begin
                buf_reg     <= data_in;
                pending_reg <= 1'b1;
            end else if (boundary) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // While reset is held, the digits are forced dark; dp follows digit 0 during reset.
    always_comb begin
        dark    = reset || guard_on || blank_mask[idx_reg];
        hex_out = shadow_reg[{idx_reg, 2'b00} +: 4];
        anode   = dark ? 8'hFF : ~(8'b1 << idx_reg);
        if (reset) begin
            dp = ~dp_in[0];
        end else if (dark) begin
            dp = 1'b1;
        end else begin
            dp = ~dp_in[idx_reg];
        end
    end

    assign pending     = pending_reg;
    assign frame_start = frame_start_reg;

endmodule
